// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared route codes, statistics sizing and saturating-increment helper
package demux_pkg;

    localparam logic DEMUX_SEL_A = 1'b0;
    localparam logic DEMUX_SEL_B = 1'b1;

    localparam int                STAT_W   = 8;
    localparam logic [STAT_W-1:0] STAT_MAX = 8'hFF;

    // Counters hold at STAT_MAX instead of rolling over.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        if (value == STAT_MAX) begin
            return value;
        end
        return value + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/demux_fifo.sv
// rtl/demux_fifo.sv - synchronous FIFO with push/pop/full/empty/head, wrap-bit pointers
module demux_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Full refuses a push even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/demux_one_two_buf.sv
// rtl/demux_one_two_buf.sv - 1:2 stream steering into per-output FIFOs
// Optional pop counters enabled by defining DEMUX_STATS_EN.
module demux_one_two_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              a_valid,
    output logic [WIDTH-1:0]  a_data,
    input  logic              a_ready,
    output logic              b_valid,
    output logic [WIDTH-1:0]  b_data,
    input  logic              b_ready,
    output logic [STAT_W-1:0] a_count,
    output logic [STAT_W-1:0] b_count
);

    logic a_full, a_empty, b_full, b_empty;
    logic a_push, b_push;
    logic accept;

    // Ready looks only at the addressed FIFO so a stalled consumer never blocks the other lane.
    assign in_ready = (in_sel == DEMUX_SEL_B) ? !b_full : !a_full;
    assign accept   = in_valid && in_ready;
    assign a_push   = accept && (in_sel == DEMUX_SEL_A);
    assign b_push   = accept && (in_sel == DEMUX_SEL_B);

    assign a_valid = !a_empty;
    assign b_valid = !b_empty;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push),
        .push_data (in_data),
        .pop       (a_ready),
        .full      (a_full),
        .empty     (a_empty),
        .head      (a_data)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_push),
        .push_data (in_data),
        .pop       (b_ready),
        .full      (b_full),
        .empty     (b_empty),
        .head      (b_data)
    );

`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] a_count_q, a_count_d;
    logic [STAT_W-1:0] b_count_q, b_count_d;

    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (a_valid && a_ready) begin
            a_count_d = sat_inc(a_count_q);
        end
        if (b_valid && b_ready) begin
            b_count_d = sat_inc(b_count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;
`else
    assign a_count = '0;
    assign b_count = '0;
`endif

endmodule

// File: tb/tb_demux_one_two_buf.sv
// tb/tb_demux_one_two_buf.sv - directed self-checking bench for demux_one_two_buf
module tb_demux_one_two_buf;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic [7:0]       a_count;
    logic [7:0]       b_count;

    int n_checks;
    int n_fails;

    demux_one_two_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .in_ready (in_ready),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] beat_tbl [10];
    int               idx;
    int               cyc;
    logic             exp_ready;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat_tbl[i] = WIDTH'((i * 7 + 3) % 16);
        end

        // Reset values
        tick();
        tick();
        expect_eq("rst_a_valid", a_valid, 0);
        expect_eq("rst_b_valid", b_valid, 0);
        expect_eq("rst_in_ready", in_ready, 1);
        expect_eq("rst_a_data", a_data, 0);
        expect_eq("rst_b_data", b_data, 0);
        expect_eq("rst_a_count", a_count, 0);
        expect_eq("rst_b_count", b_count, 0);
        rst_n = 1'b1;
        tick();

        // Routing
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h3;
        tick();
        in_sel = 1'b1; in_data = 4'hC;
        tick();
        in_valid = 1'b0;
        #1;
        expect_eq("route_a_valid", a_valid, 1);
        expect_eq("route_a_data", a_data, 4'h3);
        expect_eq("route_b_valid", b_valid, 1);
        expect_eq("route_b_data", b_data, 4'hC);
        a_ready = 1'b1; b_ready = 1'b1;
        tick();
        expect_eq("route_a_drained", a_valid, 0);
        expect_eq("route_b_drained", b_valid, 0);

        // Back-pressure on A only
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h1;
        tick();
        in_data = 4'h2;
        tick();
        #1;
        expect_eq("bp_ready_sel_a", in_ready, 0);
        in_sel = 1'b1; in_data = 4'hF;
        #1;
        expect_eq("bp_ready_sel_b", in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        expect_eq("bp_b_valid", b_valid, 1);
        expect_eq("bp_b_data", b_data, 4'hF);
        expect_eq("bp_a_head", a_data, 4'h1);
        b_ready = 1'b1;
        tick();
        expect_eq("bp_b_drained", b_valid, 0);
        b_ready = 1'b0;

        // Full FIFO refuses push even with a simultaneous pop
        a_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h7;
        #1;
        expect_eq("full_refuse_ready", in_ready, 0);
        tick();
        a_ready = 1'b0;
        #1;
        expect_eq("full_after_pop_ready", in_ready, 1);
        expect_eq("full_head_2", a_data, 4'h2);
        tick();
        in_valid = 1'b0;
        a_ready  = 1'b1;
        #1;
        expect_eq("order_0", a_data, 4'h2);
        tick();
        expect_eq("order_1_valid", a_valid, 1);
        expect_eq("order_1", a_data, 4'h7);
        tick();
        expect_eq("order_empty", a_valid, 0);
        a_ready = 1'b0;

        // Wrap: alternating routes, random readies, scoreboard
        idx = 0;
        cyc = 0;
        while ((idx < 10 || qa.size() != 0 || qb.size() != 0) && cyc < 200) begin
            a_ready = 1'($urandom_range(0, 1));
            b_ready = 1'($urandom_range(0, 1));
            if (idx < 10) begin
                in_valid = 1'b1;
                in_sel   = 1'(idx % 2);
                in_data  = beat_tbl[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_ready = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
            expect_eq("wrap_in_ready", in_ready, exp_ready);
            expect_eq("wrap_a_valid", a_valid, qa.size() != 0);
            expect_eq("wrap_b_valid", b_valid, qb.size() != 0);
            if (qa.size() != 0 && a_ready) begin
                expect_eq("wrap_a_data", a_data, qa.pop_front());
            end
            if (qb.size() != 0 && b_ready) begin
                expect_eq("wrap_b_data", b_data, qb.pop_front());
            end
            if (in_valid && exp_ready) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        expect_eq("wrap_no_timeout", cyc < 200, 1);
        expect_eq("wrap_all_sent", idx, 10);
        #1;
        expect_eq("wrap_a_empty", a_valid, 0);
        expect_eq("wrap_b_empty", b_valid, 0);

        // Reset mid-traffic
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h5;
        tick();
        in_sel = 1'b1; in_data = 4'h6;
        tick();
        in_valid = 1'b0; in_sel = 1'b0;
        expect_eq("mid_pre_a_valid", a_valid, 1);
        rst_n = 1'b0;
        #1;
        expect_eq("mid_rst_a_valid", a_valid, 0);
        expect_eq("mid_rst_b_valid", b_valid, 0);
        expect_eq("mid_rst_in_ready", in_ready, 1);
        expect_eq("mid_rst_a_count", a_count, 0);
        expect_eq("mid_rst_b_count", b_count, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Counter saturation: 300 pops on A
        a_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_data = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        expect_eq("stat_a_drained", a_valid, 0);
`ifdef DEMUX_STATS_EN
        expect_eq("stat_a_sat", a_count, 8'hFF);
        expect_eq("stat_b_idle", b_count, 0);
`else
        expect_eq("stat_a_tied", a_count, 0);
        expect_eq("stat_b_tied", b_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
